uart_tx_fifo: RTL and testbench

//  Programming-UART transmitter; the return path for the programming receiver on io_rx_i.

---
 rtl/uart_tx_fifo.sv | 152 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter (LSB first).
// The bit time is a runtime divisor latched at the start of each frame, so one
// frame always runs at a single rate. Back-to-back frames leave no idle gap.
module uart_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] io_CLK_PER_BIT,
    input  logic [7:0]  io_tx_data_i,
    input  logic        io_tx_valid_i,
    output logic        io_tx_ready_o,
    output logic        io_tx_o,
    output logic        io_busy_o,
    output logic        io_frame_done_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // FIFO storage and bookkeeping
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;

    // Transmitter state
    state_e      state_q;
    logic [7:0]  shift_q;
    logic [15:0] div_q;
    logic [15:0] baud_cnt_q;
    logic [2:0]  bit_idx_q;
    logic        tx_q;
    logic        frame_done_q;

    logic        push;
    logic        pop;
    logic        last_cycle;
    logic        can_start;
    logic [15:0] baud_nxt;

    // Ready depends only on the registered count, never on a same-cycle pop.
    assign io_tx_ready_o   = (count_q != CntFull);
    assign io_tx_o         = tx_q;
    assign io_frame_done_o = frame_done_q;
    assign io_busy_o       = (state_q != StIdle) || (count_q != '0);

    // Handshake, pop decision and FIFO count update
    always_comb begin
        push       = io_tx_valid_i && io_tx_ready_o;
        baud_nxt   = baud_cnt_q + 16'd1;
        last_cycle = (baud_cnt_q == div_q - 16'd1);
        can_start  = (count_q != '0) && (io_CLK_PER_BIT != 16'd0);
        // A new frame starts from IDLE or straight out of the last stop-bit cycle.
        pop        = can_start && ((state_q == StIdle) || ((state_q == StStop) && last_cycle));
        count_d    = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers, count and storage writes
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= io_tx_data_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    // Frame FSM with registered line and frame-done outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            div_q        <= '0;
            baud_cnt_q   <= '0;
            bit_idx_q    <= '0;
            tx_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (pop) begin
                shift_q    <= mem_q[rd_ptr_q];
                div_q      <= io_CLK_PER_BIT;
                baud_cnt_q <= '0;
                bit_idx_q  <= '0;
                tx_q       <= 1'b0;
                state_q    <= StStart;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        tx_q <= 1'b1;
                    end
                    StStart: begin
                        if (last_cycle) begin
                            baud_cnt_q <= '0;
                            tx_q       <= shift_q[0];
                            state_q    <= StData;
                        end else begin
                            baud_cnt_q <= baud_nxt;
                        end
                    end
                    StData: begin
                        if (last_cycle) begin
                            baud_cnt_q <= '0;
                            shift_q    <= shift_q >> 1;
                            if (bit_idx_q == 3'd7) begin
                                tx_q    <= 1'b1;
                                state_q <= StStop;
                                // With a one-cycle bit the first stop cycle is also the last.
                                frame_done_q <= (div_q == 16'd1);
                            end else begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                                tx_q      <= shift_q[1];
                            end
                        end else begin
                            baud_cnt_q <= baud_nxt;
                        end
                    end
                    StStop: begin
                        if (last_cycle) begin
                            tx_q    <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            baud_cnt_q <= baud_nxt;
                            // Raise the pulse so it is visible during the final stop cycle.
                            frame_done_q <= (baud_nxt == div_q - 16'd1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo. Bytes are queued with the
// bit time they should go out at; a line monitor decodes every frame cycle by cycle.
module tb_uart_tx_fifo;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] cpb = 16'd0;
    logic [7:0]  data = 8'd0;
    logic        valid = 1'b0;
    logic        ready;
    logic        tx;
    logic        busy;
    logic        done;

    uart_tx_fifo #(.FIFO_DEPTH(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_CLK_PER_BIT (cpb),
        .io_tx_data_i   (data),
        .io_tx_valid_i  (valid),
        .io_tx_ready_o  (ready),
        .io_tx_o        (tx),
        .io_busy_o      (busy),
        .io_frame_done_o(done)
    );

    int n_total = 0;
    int n_bad = 0;
    int cyc = 0;

    // Scoreboard entry: {bit time, byte}
    logic [23:0] sb [$];

    int          mon_active = 0;
    int          mon_k = 0;
    int          mon_div = 1;
    logic [7:0]  mon_byte = 8'd0;
    int          n_frames = 0;
    int          n_done = 0;
    int          last_start = 0;
    int          prev_start = 0;

    initial forever #5 clock = ~clock;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Line monitor: sampled on the falling edge, away from the active edge.
    initial forever begin
        logic [23:0] e;
        int          bi;
        logic        expb;
        @(negedge clock);
        if (!reset) begin
            mon_active = 0;
        end else begin
            if (done === 1'b1) n_done++;
            if (mon_active == 0) begin
                if (tx === 1'b0) begin
                    if (sb.size() == 0) begin
                        check("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        e          = sb.pop_front();
                        mon_byte   = e[7:0];
                        mon_div    = int'(e[23:8]);
                        mon_active = 1;
                        mon_k      = 0;
                        prev_start = last_start;
                        last_start = cyc;
                        n_frames++;
                    end
                end else begin
                    check("idle_done", {31'd0, done}, 32'd0);
                end
            end
            if (mon_active != 0) begin
                bi = mon_k / mon_div;
                if (bi == 0) expb = 1'b0;
                else if (bi == 9) expb = 1'b1;
                else expb = mon_byte[bi-1];
                check("tx_bit", {31'd0, tx}, {31'd0, expb});
                check("frame_done", {31'd0, done}, {31'd0, (mon_k == 10 * mon_div - 1)});
                check("busy_in_frame", {31'd0, busy}, 32'd1);
                mon_k++;
                if (mon_k == 10 * mon_div) mon_active = 0;
            end
        end
    end

    // Offer a byte and leave valid high; returns just after the accepting edge.
    task automatic push_byte(input logic [7:0] b, input int div);
        int n = 0;
        data  = b;
        valid = 1'b1;
        @(negedge clock);
        while (ready !== 1'b1 && n < 2000) begin
            n++;
            @(negedge clock);
        end
        if (ready !== 1'b1) check("push_timeout", 32'd0, 32'd1);
        else sb.push_back({16'(div), b});
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while ((busy !== 1'b0 || mon_active != 0 || sb.size() != 0) && n < 5000) begin
            n++;
            @(negedge clock);
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);
    endtask

    initial begin
        int d0;
        int f0;
        int p;
        int n;

        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd1);

        // 1: single byte, 4-cycle bits, one-cycle latency to start bit
        @(posedge clock);
        #1 cpb = 16'd4;
        d0 = n_done;
        push_byte(8'hA5, 4);
        p = cyc;
        valid = 1'b0;
        wait_idle();
        check("t1_latency", last_start, p + 1);
        check("t1_done_count", n_done - d0, 32'd1);

        // 2: back-to-back frames, no idle gap
        @(posedge clock);
        #1 cpb = 16'd2;
        d0 = n_done;
        f0 = n_frames;
        push_byte(8'h00, 2);
        push_byte(8'hFF, 2);
        valid = 1'b0;
        wait_idle();
        check("t2_frames", n_frames - f0, 32'd2);
        check("t2_done_count", n_done - d0, 32'd2);
        check("t2_gap", last_start - prev_start, 32'd20);

        // 3: six bytes with valid held; FIFO fills and back-pressures
        @(posedge clock);
        #1 cpb = 16'd4;
        f0 = n_frames;
        for (int i = 0; i < 6; i++) begin
            push_byte(8'(8'h17 + 8'(i * 37)), 4);
            if (i == 4) check("t3_ready_full", {31'd0, ready}, 32'd0);
        end
        valid = 1'b0;
        wait_idle();
        check("t3_frames", n_frames - f0, 32'd6);

        // 4: reset pulse mid-DATA aborts the frame and drops queued bytes
        @(posedge clock);
        #1 cpb = 16'd4;
        push_byte(8'h3C, 4);
        push_byte(8'h55, 4);
        valid = 1'b0;
        repeat (12) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        sb.delete();
        d0 = n_done;
        @(negedge clock);
        check("t4_tx", {31'd0, tx}, 32'd1);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_ready", {31'd0, ready}, 32'd1);
        check("t4_done", {31'd0, done}, 32'd0);
        repeat (60) @(negedge clock);
        check("t4_no_done", n_done - d0, 32'd0);
        check("t4_still_idle", {31'd0, busy}, 32'd0);

        // 5: halted transmitter holds queued bytes until a divisor appears
        @(posedge clock);
        #1 cpb = 16'd0;
        push_byte(8'h81, 8);
        push_byte(8'h6E, 8);
        valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("t5_line_high", {31'd0, tx}, 32'd1);
        end
        check("t5_ready", {31'd0, ready}, 32'd1);
        check("t5_busy", {31'd0, busy}, 32'd1);
        @(posedge clock);
        #1 cpb = 16'd8;
        p = cyc;
        wait_idle();
        check("t5_start", prev_start, p + 1);
        check("t5_gap", last_start - prev_start, 32'd80);

        // 6: divisor change mid-frame applies only to the next frame
        @(posedge clock);
        #1 cpb = 16'd4;
        f0 = n_frames;
        push_byte(8'hC3, 4);
        push_byte(8'h5A, 8);
        valid = 1'b0;
        n = 0;
        while (n_frames == f0 && n < 100) begin
            n++;
            @(posedge clock);
        end
        check("t6_started", n_frames - f0, 32'd1);
        repeat (5) @(posedge clock);
        #1 cpb = 16'd8;
        wait_idle();
        check("t6_frames", n_frames - f0, 32'd2);
        check("t6_gap", last_start - prev_start, 32'd40);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
